if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the five-stage MIPS pipeline, directly upstream of the decode stage. It owns the program counter, drives the instruction-memory word address, and registers the fetched instruction into the IF/ID pipeline register (`out_pc`, `out_ir`), which feeds decode's `in_pc`/`in_ir`. It handles stalls, flushes, redirects from branch/jump resolution, and the halt that follows an exit syscall.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `IMEM_AW`, 10, instruction-memory word-address width.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  hazard unit: hold PC and IF/ID.
- `flush`  in  1  load a bubble into IF/ID.
- `redirect`  in  1  take `redirect_pc` as the next PC.
- `redirect_pc`  in  32  branch/jump target.
- `halt`  in  1  exit syscall observed downstream; stop fetching.
- `imem_addr`  out  IMEM_AW  word address, `pc[IMEM_AW+1:2]`.
- `imem_data`  in  32  combinational ROM read data for `imem_addr`.
- `out_pc`  out  32  PC+4 of the instruction in IF/ID.
- `out_ir`  out  32  instruction in IF/ID (NOP = 32'h0).
- `out_valid`  out  1  IF/ID holds a real instruction.
- `fetch_count`  out  32  number of instructions that have entered IF/ID.
- `halted`  out  1  stage is in HALTED.

## Operation
- FSM states: RUN, HALTED. `rst` → RUN. RUN + `halt` → HALTED. HALTED leaves only on `rst`.
- Next-PC priority, evaluated every cycle: `rst` > HALTED or `halt` (hold) > `redirect` (`redirect_pc` with bits [1:0] forced to 0) > `stall` (hold) > `pc + 4`.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0. `imem_addr` drops PC bits above `IMEM_AW+1`.
- IF/ID update priority: `rst` > `halt`, HALTED, `redirect`, or `flush` (bubble: `out_ir`=0, `out_pc`=0, `out_valid`=0) > `stall` (hold all three) > load (`out_ir`=`imem_data`, `out_pc`=`pc+4`, `out_valid`=1).
- `redirect` overrides a simultaneous `stall`: the PC moves and IF/ID is bubbled.
- `flush` without `redirect` bubbles IF/ID only; the PC still follows the next-PC priority.
- `fetch_count` increments on each IF/ID load with `out_valid` going 1 and saturates at 32'hFFFF_FFFF. Holds during stall and bubbles.

## Timing
- Reset values: `pc`=`RESET_PC`, `out_pc`=0, `out_ir`=0, `out_valid`=0, `fetch_count`=0, `halted`=0, state RUN.
- `imem_addr` is combinational from the PC register. The instruction is read in the same cycle.
- IF/ID latency is one cycle: the instruction at PC p appears on `out_ir` on the edge after `imem_addr` presents p.
- `redirect` asserted in cycle n: `imem_addr` shows the target in cycle n+1, and its instruction is valid on `out_ir` at the end of cycle n+1. Exactly one bubble is inserted.
- `halt` asserted in cycle n: `halted`=1 and `out_valid`=0 from edge n+1. PC is frozen at its cycle-n value.
- `rst` mid-operation: all state returns to reset values on that edge, regardless of the other inputs.

## Structure
- Shared package `mips_pkg` holds:
  - `NOP_INSTR` = 32'h0;
  - the default `RESET_PC`;
  - the `if_state_t` enum (RUN, HALTED).
- Sub-module `if_id_reg` holds `out_pc`, `out_ir`, and `out_valid`, with inputs load, hold, and bubble. It is reusable for later pipeline registers.
- The PC, next-PC mux, FSM, and counter live in `if_stage`.

## Test plan
- Reset with `RESET_PC`=0 and ROM words 0..3 = 0x20020001, 0x20030002, 0x00621020, 0x0000000C:
  - after 4 edges, `out_ir` has been 0x20020001, 0x20030002, 0x00621020 in order, with `out_pc` 4, 8, 12;
  - `fetch_count`=3.
- Stall for 2 cycles after the second fetch:
  - `out_ir` holds 0x20030002 and `imem_addr` holds 2;
  - `fetch_count` does not increment;
  - fetching resumes at word 2.
- `redirect`=1 with `redirect_pc`=0x0000_0040, together with `stall`=1:
  - next cycle `out_valid`=0 and `imem_addr`=16;
  - the following cycle `out_pc`=0x44.
- `redirect_pc`=0x0000_0043: the PC loads 0x40.
- `flush` alone: one bubble in IF/ID and the PC keeps advancing.
- `halt` pulse:
  - `halted`=1 and `out_valid`=0 thereafter, with the PC frozen;
  - `rst` returns `halted`=0, PC=0, `fetch_count`=0.
- PC = 0xFFFF_FFFC with no stall: next PC = 0 and `out_pc` = 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline stages.
package mips_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } if_state_t;

endpackage

// File: rtl/if_id_reg.sv
// Generic PC/IR pipeline register with bubble, hold and load controls.
module if_id_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        hold,
  input  logic        bubble,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_ir,
  output logic [31:0] out_pc,
  output logic [31:0] out_ir,
  output logic        out_valid
);

  logic [31:0] pc_d, pc_q;
  logic [31:0] ir_d, ir_q;
  logic        valid_d, valid_q;

  // Bubble beats hold beats load; with no control asserted the register holds.
  always_comb begin
    pc_d    = pc_q;
    ir_d    = ir_q;
    valid_d = valid_q;
    if (bubble) begin
      pc_d    = '0;
      ir_d    = NOP_INSTR;
      valid_d = 1'b0;
    end else if (hold) begin
      pc_d    = pc_q;
      ir_d    = ir_q;
      valid_d = valid_q;
    end else if (load) begin
      pc_d    = in_pc;
      ir_d    = in_ir;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      ir_q    <= NOP_INSTR;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
    end
  end

  assign out_pc    = pc_q;
  assign out_ir    = ir_q;
  assign out_valid = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, next-PC selection, halt FSM,
// fetch counter and the IF/ID pipeline register.
module if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned IMEM_AW  = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  input  logic               halt,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_data,
  output logic [31:0]        out_pc,
  output logic [31:0]        out_ir,
  output logic               out_valid,
  output logic [31:0]        fetch_count,
  output logic               halted
);

  if_state_t   state_d, state_q;
  logic [31:0] pc_d, pc_q;
  logic [31:0] fetch_count_d, fetch_count_q;
  logic [31:0] pc_plus4;
  logic        frozen;
  logic        ifid_bubble;
  logic        ifid_load;
  logic        unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign pc_plus4    = pc_q + 32'd4;
  assign frozen      = (state_q == HALTED) || halt;
  assign ifid_bubble = frozen || redirect || flush;
  assign ifid_load   = !ifid_bubble && !stall;

  always_comb begin
    state_d = state_q;
    if (state_q == RUN && halt) begin
      state_d = HALTED;
    end
  end

  always_comb begin
    pc_d = pc_plus4;
    if (frozen) begin
      pc_d = pc_q;
    end else if (redirect) begin
      pc_d = {redirect_pc[31:2], 2'b00};
    end else if (stall) begin
      pc_d = pc_q;
    end
  end

  always_comb begin
    fetch_count_d = fetch_count_q;
    if (ifid_load && (fetch_count_q != '1)) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  if_id_reg u_if_id (
    .clk       (clk),
    .rst       (rst),
    .load      (ifid_load),
    .hold      (stall),
    .bubble    (ifid_bubble),
    .in_pc     (pc_plus4),
    .in_ir     (imem_data),
    .out_pc    (out_pc),
    .out_ir    (out_ir),
    .out_valid (out_valid)
  );

  assign imem_addr   = pc_q[IMEM_AW+1:2];
  assign fetch_count = fetch_count_q;
  assign halted      = (state_q == HALTED);

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: reference model predicts every cycle's outputs.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, redirect, halt;
  logic [31:0] redirect_pc;
  logic [9:0]  imem_addr;
  logic [31:0] imem_data;
  logic [31:0] out_pc, out_ir, fetch_count;
  logic        out_valid, halted;

  logic [31:0] rom [0:1023];
  assign imem_data = rom[imem_addr];

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(32'h0000_0000), .IMEM_AW(10)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .out_pc(out_pc), .out_ir(out_ir), .out_valid(out_valid),
    .fetch_count(fetch_count), .halted(halted)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
    logic        valid;
    logic [31:0] cnt;
    logic        halted;
    logic [9:0]  addr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   done     = 0;

  // Architectural reference state
  logic [31:0] m_pc, m_opc, m_ir, m_cnt;
  logic        m_valid, m_halted;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Next-cycle prediction straight from the stage's rules.
  task automatic model(input bit r, input bit st, input bit fl, input bit rd,
                       input logic [31:0] rpc, input bit h);
    logic [31:0] word, next_pc;
    bit frozen;
    if (r) begin
      m_pc = 32'h0; m_opc = 0; m_ir = 0; m_valid = 0; m_cnt = 0; m_halted = 0;
      return;
    end
    word   = rom[m_pc[11:2]];
    frozen = m_halted || h;
    if (frozen)      next_pc = m_pc;
    else if (rd)     next_pc = rpc & 32'hFFFF_FFFC;
    else if (st)     next_pc = m_pc;
    else             next_pc = m_pc + 4;
    if (frozen || rd || fl) begin
      m_opc = 0; m_ir = 0; m_valid = 0;
    end else if (!st) begin
      m_opc = m_pc + 4; m_ir = word; m_valid = 1;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end
    m_pc = next_pc;
    if (h) m_halted = 1;
  endtask

  task automatic step(input bit r, input bit st, input bit fl, input bit rd,
                      input logic [31:0] rpc, input bit h);
    exp_t e;
    rst = r; stall = st; flush = fl; redirect = rd; redirect_pc = rpc; halt = h;
    model(r, st, fl, rd, rpc, h);
    e.pc = m_opc; e.ir = m_ir; e.valid = m_valid; e.cnt = m_cnt;
    e.halted = m_halted; e.addr = m_pc[11:2];
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 32'h0, 0);
  endtask

  // Monitor: compares the DUT against the oldest prediction after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out_pc",      out_pc,              e.pc);
        chk("out_ir",      out_ir,              e.ir);
        chk("out_valid",   {31'b0, out_valid},  {31'b0, e.valid});
        chk("fetch_count", fetch_count,         e.cnt);
        chk("halted",      {31'b0, halted},     {31'b0, e.halted});
        chk("imem_addr",   {22'b0, imem_addr},  {22'b0, e.addr});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned rr;
    logic [31:0] rpc;
    for (int unsigned i = 0; i < 1024; i++) rom[i] = $urandom;
    rom[0] = 32'h2002_0001; rom[1] = 32'h2003_0002;
    rom[2] = 32'h0062_1020; rom[3] = 32'h0000_000C;
    rst = 1; stall = 0; flush = 0; redirect = 0; redirect_pc = 0; halt = 0;
    m_pc = 0; m_opc = 0; m_ir = 0; m_valid = 0; m_cnt = 0; m_halted = 0;

    step(1, 0, 0, 0, 32'h0, 0);
    chk("reset_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_count", fetch_count, 32'd0);
    run(3);
    chk("seq_ir3", out_ir, 32'h0062_1020);
    chk("seq_pc3", out_pc, 32'd12);
    chk("seq_cnt3", fetch_count, 32'd3);

    // Stall after the second fetch
    step(1, 0, 0, 0, 32'h0, 0);
    run(2);
    step(0, 1, 0, 0, 32'h0, 0);
    step(0, 1, 0, 0, 32'h0, 0);
    chk("stall_ir", out_ir, 32'h2003_0002);
    chk("stall_addr", {22'b0, imem_addr}, 32'd2);
    chk("stall_cnt", fetch_count, 32'd2);
    run(1);
    chk("resume_ir", out_ir, 32'h0062_1020);

    // Redirect beats stall
    step(0, 1, 0, 1, 32'h0000_0040, 0);
    chk("redir_valid", {31'b0, out_valid}, 32'd0);
    chk("redir_addr", {22'b0, imem_addr}, 32'd16);
    run(1);
    chk("redir_pc", out_pc, 32'h44);
    step(0, 0, 0, 1, 32'h0000_0043, 0);
    chk("redir_align", {22'b0, imem_addr}, 32'd16);
    run(2);

    // Flush alone
    step(0, 0, 1, 0, 32'h0, 0);
    chk("flush_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_addr", {22'b0, imem_addr}, 32'd19);

    // Halt, then reset out of it
    step(0, 0, 0, 0, 32'h0, 1);
    chk("halt_flag", {31'b0, halted}, 32'd1);
    run(3);
    chk("halt_addr", {22'b0, imem_addr}, 32'd19);
    step(1, 0, 0, 0, 32'h0, 0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_addr", {22'b0, imem_addr}, 32'd0);

    // PC wrap
    step(0, 0, 0, 1, 32'hFFFF_FFFC, 0);
    run(1);
    chk("wrap_outpc", out_pc, 32'd0);
    chk("wrap_addr", {22'b0, imem_addr}, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      rr  = $urandom_range(0, 255);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      step(rr == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 7) == 0, rpc, rr == 1);
    end

    @(posedge clk);
    #3;
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
